device_ctrl_mc: RTL and testbench

- Parametrised multi-channel successor to the single-device read/write controller.
- Accepts one CPU-side read/write request at a time over a valid/ready handshake and decodes the upper address bits to one of N_DEV device channels.
- Drives that channel's select/rw/addr/wdata, waits for the device ack with a timeout, and returns read data or an error over a valid/ready response channel.
- Sits between the processor bus master and the peripheral devices.

---
 rtl/device_ctrl_mc_pkg.sv | 29 ++
 rtl/device_ctrl_mc_timeout_cnt.sv | 31 +++
 rtl/device_ctrl_mc.sv | 157 +++++++++++++++
 tb/tb_device_ctrl_mc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/device_ctrl_mc_pkg.sv
// Shared types and constants for the multi-channel device controller (package device_ctrl_pkg).
// The status-register fields here are only used when DEVICE_CTRL_STATUS_EN is defined.
package device_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  // Widest device count onehot() can encode; callers size-cast down to N_DEV.
  localparam int MAX_DEV = 64;

  // All-ones address; callers slice it to their own address width.
  localparam logic [63:0] STATUS_ADDR = '1;

  localparam int TXN_CNT_W  = 16;
  localparam int ERR_CNT_W  = 8;
  localparam int LAST_IDX_W = 8;
  localparam int STATUS_W   = TXN_CNT_W + ERR_CNT_W + LAST_IDX_W;

  function automatic logic [MAX_DEV-1:0] onehot(input int unsigned idx);
    logic [MAX_DEV-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/device_ctrl_mc_timeout_cnt.sv
// Ack-timeout counter for device_ctrl_mc: cleared by load, counts up on inc,
// and stops at TIMEOUT-1 where the terminal-count flag is raised.
module dev_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is always written with <= so every register in the
  // design samples the values from before the clock edge, independent of order.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)
      count <= '0;
    else if (load)
      count <= '0;
    else if (inc && !tc)
      count <= count + 1'b1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/device_ctrl_mc.sv
// Multi-channel device read/write controller: one request at a time, decoded by
// the top address bits to N_DEV channels, with ack timeout. DEVICE_CTRL_STATUS_EN
// adds an internal status register at the all-ones address.
module device_ctrl_mc
  import device_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_DEV   = 4,
  parameter int SEL_W   = $clog2(N_DEV),
  parameter int TIMEOUT = 15
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    resp_err,
  output logic [N_DEV-1:0]        dev_sel,
  output logic                    dev_rw,
  output logic [ADDR_W-SEL_W-1:0] dev_addr,
  output logic [DATA_W-1:0]       dev_wdata,
  input  logic [N_DEV*DATA_W-1:0] dev_rdata,
  input  logic [N_DEV-1:0]        dev_ack
);

  state_e             state;
  logic [SEL_W-1:0]   cur_idx;
  logic [SEL_W-1:0]   req_idx;
  logic               accept;
  logic               ack_hit;
  logic               cnt_tc;
  logic               access_done;
  logic               access_timeout;
  logic [DATA_W-1:0]  sel_rdata;
  logic               status_hit;
  logic [STATUS_W-1:0] status_word;

  assign req_idx        = req_addr[ADDR_W-1 -: SEL_W];
  assign accept         = (state == IDLE) && req_ready && req_valid;
  assign ack_hit        = dev_ack[cur_idx];
  assign sel_rdata      = dev_rdata[cur_idx*DATA_W +: DATA_W];
  assign access_done    = (state == ACCESS) && (ack_hit || cnt_tc);
  assign access_timeout = (state == ACCESS) && !ack_hit && cnt_tc;

  dev_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .load     (accept),
    .inc      (state == ACCESS),
    .tc       (cnt_tc)
  );

`ifdef DEVICE_CTRL_STATUS_EN
  logic [TXN_CNT_W-1:0]  txn_count;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [LAST_IDX_W-1:0] last_idx;

  assign status_hit  = (req_addr == STATUS_ADDR[ADDR_W-1:0]);
  assign status_word = {txn_count, err_count, last_idx};

  // A status write takes priority; it cannot coincide with a completing access.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      txn_count <= '0;
      err_count <= '0;
      last_idx  <= '0;
    end else if (accept && status_hit && req_rw) begin
      txn_count <= '0;
      err_count <= '0;
    end else if (access_done) begin
      last_idx <= LAST_IDX_W'(cur_idx);
      if (txn_count != '1)
        txn_count <= txn_count + 1'b1;
      if (access_timeout && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end
`else
  assign status_hit  = 1'b0;
  assign status_word = '0;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      cur_idx    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      dev_sel    <= '0;
      dev_rw     <= 1'b0;
      dev_addr   <= '0;
      dev_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            if (status_hit) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= req_rw ? '0 : DATA_W'(status_word);
            end else begin
              state     <= ACCESS;
              cur_idx   <= req_idx;
              dev_sel   <= N_DEV'(onehot(32'(req_idx)));
              dev_rw    <= req_rw;
              dev_addr  <= req_addr[ADDR_W-SEL_W-1:0];
              dev_wdata <= req_wdata;
            end
          end
        end

        ACCESS: begin
          // Ack is tested first so an ack on the terminal-count cycle still succeeds.
          if (ack_hit) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= dev_rw ? '0 : sel_rdata;
            dev_sel    <= '0;
          end else if (cnt_tc) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            dev_sel    <= '0;
          end
        end

        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_device_ctrl_mc.sv
// Directed self-checking bench for device_ctrl_mc (default parameters); the status
// register section follows DEVICE_CTRL_STATUS_EN.
module tb_device_ctrl_mc;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int N_DEV   = 4;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 15;

  logic                    CLOCK_50 = 1'b0;
  logic                    RESET_N  = 1'b0;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic                    req_rw = 1'b0;
  logic [ADDR_W-1:0]       req_addr = '0;
  logic [DATA_W-1:0]       req_wdata = '0;
  logic                    resp_valid;
  logic                    resp_ready = 1'b0;
  logic [DATA_W-1:0]       resp_rdata;
  logic                    resp_err;
  logic [N_DEV-1:0]        dev_sel;
  logic                    dev_rw;
  logic [ADDR_W-SEL_W-1:0] dev_addr;
  logic [DATA_W-1:0]       dev_wdata;
  logic [N_DEV*DATA_W-1:0] dev_rdata;
  logic [N_DEV-1:0]        dev_ack = '0;

  int n_checks = 0;
  int n_fail   = 0;

  device_ctrl_mc #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .N_DEV   (N_DEV),
    .SEL_W   (SEL_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dev_sel    (dev_sel),
    .dev_rw     (dev_rw),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_rdata  (dev_rdata),
    .dev_ack    (dev_ack)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  // Presents one request; returns on the negedge after acceptance (cycle 1).
  task automatic send(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    int waited;
    waited = 0;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("req_ready_before_send", req_ready, 1);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cycles);
    cycles = 0;
    while (!resp_valid && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic take_resp(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, resp_valid, 0);
    check({tag, "_req_ready"}, req_ready, 1);
  endtask

  task automatic read_acked(input logic [ADDR_W-1:0] addr, input int idx);
    send(1'b0, addr, '0);
    dev_ack = N_DEV'(1 << idx);
    tick();
    dev_ack = '0;
    check("acked_rdata", resp_rdata, 64'(32'hCAFE_0000 | idx));
    take_resp("acked");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int k = 0; k < N_DEV; k++)
      dev_rdata[k*DATA_W +: DATA_W] = 32'hCAFE_0000 | k;

    // Reset state
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_dev_sel", dev_sel, 0);
    check("rst_dev_addr", dev_addr, 0);
    RESET_N = 1'b1;
    tick();
    check("idle_req_ready", req_ready, 1);

    // Read device 2 with immediate ack
    send(1'b0, 32'h8000_0010, '0);
    check("rd2_dev_sel", dev_sel, 4'b0100);
    check("rd2_dev_addr", dev_addr, 30'h10);
    check("rd2_dev_rw", dev_rw, 0);
    check("rd2_req_ready", req_ready, 0);
    dev_ack = 4'b0100;
    tick();
    dev_ack = '0;
    check("rd2_resp_valid", resp_valid, 1);
    check("rd2_resp_rdata", resp_rdata, 32'hCAFE_0002);
    check("rd2_resp_err", resp_err, 0);
    check("rd2_dev_sel_off", dev_sel, 0);
    take_resp("rd2");

    // Write device 0, ack three cycles after select
    send(1'b1, 32'h0000_0004, 32'h2);
    check("wr0_dev_sel", dev_sel, 4'b0001);
    check("wr0_dev_rw", dev_rw, 1);
    check("wr0_dev_wdata", dev_wdata, 32'h2);
    tick();
    tick();
    check("wr0_no_resp_yet", resp_valid, 0);
    dev_ack = 4'b0001;
    tick();
    dev_ack = '0;
    check("wr0_resp_valid", resp_valid, 1);
    check("wr0_resp_rdata", resp_rdata, 0);
    check("wr0_resp_err", resp_err, 0);
    take_resp("wr0");

    // Read device 1, no ack: timeout
    send(1'b0, 32'h4000_0020, '0);
    check("to_dev_sel", dev_sel, 4'b0010);
    wait_resp(cyc);
    check("to_latency", 64'(cyc), TIMEOUT);
    check("to_resp_err", resp_err, 1);
    check("to_resp_rdata", resp_rdata, 0);
    check("to_dev_sel_off", dev_sel, 0);
    take_resp("to");

    // Ack on the terminal-count cycle wins
    send(1'b0, 32'h8000_0000, '0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("edge_no_resp_yet", resp_valid, 0);
    dev_ack = 4'b0100;
    tick();
    dev_ack = '0;
    check("edge_resp_valid", resp_valid, 1);
    check("edge_resp_err", resp_err, 0);
    check("edge_resp_rdata", resp_rdata, 32'hCAFE_0002);
    take_resp("edge");

    // Wrong-channel ack ignored, then backpressure with a pending request
    send(1'b0, 32'h4000_0000, '0);
    dev_ack = 4'b1001;
    tick();
    dev_ack = '0;
    check("wch_ignored", resp_valid, 0);
    check("wch_dev_sel", dev_sel, 4'b0010);
    dev_ack = 4'b0010;
    tick();
    dev_ack = '0;
    check("wch_resp_valid", resp_valid, 1);
    check("wch_resp_rdata", resp_rdata, 32'hCAFE_0001);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 32'hC000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_rdata", resp_rdata, 32'hCAFE_0001);
      check("bp_req_ready", req_ready, 0);
      check("bp_dev_sel", dev_sel, 0);
    end
    req_valid = 1'b0;
    take_resp("bp");
    check("bp_not_captured", dev_sel, 0);

    // Reset in the middle of an access
    send(1'b1, 32'hC000_0040, 32'h55);
    check("mid_dev_sel", dev_sel, 4'b1000);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_dev_sel", dev_sel, 0);
    check("mid_rst_dev_addr", dev_addr, 0);
    check("mid_rst_dev_rw", dev_rw, 0);
    check("mid_rst_req_ready", req_ready, 0);
    dev_ack = 4'b1000;
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    dev_ack = '0;
    check("mid_no_resp", resp_valid, 0);
    check("mid_req_ready", req_ready, 1);

`ifdef DEVICE_CTRL_STATUS_EN
    read_acked(32'h0000_0000, 0);
    read_acked(32'h8000_0000, 2);
    send(1'b0, 32'h4000_0000, '0);
    wait_resp(cyc);
    check("st_to_err", resp_err, 1);
    take_resp("st_to");
    send(1'b0, 32'hFFFF_FFFF, '0);
    check("st_rd_dev_sel", dev_sel, 0);
    check("st_rd_valid", resp_valid, 1);
    check("st_rd_rdata", resp_rdata, 32'h0003_0101);
    check("st_rd_err", resp_err, 0);
    take_resp("st_rd");
    send(1'b1, 32'hFFFF_FFFF, 32'h1234);
    check("st_wr_valid", resp_valid, 1);
    check("st_wr_rdata", resp_rdata, 0);
    take_resp("st_wr");
    send(1'b0, 32'hFFFF_FFFF, '0);
    check("st_clr_rdata", resp_rdata, 32'h0000_0001);
    take_resp("st_clr");
`else
    send(1'b0, 32'hFFFF_FFFF, '0);
    check("ones_dev_sel", dev_sel, 4'b1000);
    check("ones_dev_addr", dev_addr, 30'h3FFF_FFFF);
    dev_ack = 4'b1000;
    tick();
    dev_ack = '0;
    check("ones_resp_valid", resp_valid, 1);
    check("ones_resp_rdata", resp_rdata, 32'hCAFE_0003);
    take_resp("ones");
    read_acked(32'h4000_0008, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
